csi_pkt_decoder: RTL and testbench
==================================

# csi_pkt_decoder

Two-lane MIPI CSI-2 packet decoder that sits directly upstream of the de-Bayer stage. It takes the byte-aligned 16-bit lane stream (lane1 in [15:8], lane0 in [7:0]) and parses the packet header, including the ECC check. It forwards only the RAW payload of accepted long packets as `data_out`/`data_valid`, checks the payload CRC-16, and turns short packets into frame/line strobes.

## Interface
- `RAW_DT`, 8'h2A — data type of forwarded long packets (RAW8); other long packets are consumed silently.
- `MAX_WC`, 1280 — largest accepted word count, in bytes.
- `clk` in 1 — byte clock; the single clock domain.
- `rst` in 1 — asynchronous, active-high reset.
- `data_in` in `lane_data_t` (16) — aligned lane bytes; the first byte of each pair is on lane0 [7:0].
- `data_in_valid` in 1 — high for the whole HS burst; low between packets.
- `data_out` out `lane_data_t` (16) — payload beat.
- `data_valid` out 1 — payload qualifier; high for exactly WC/2 consecutive cycles per forwarded line.
- `frame_start` out 1 — one-cycle pulse on an FS short packet (DT 0x00).
- `frame_end` out 1 — one-cycle pulse on an FE short packet (DT 0x01).
- `line_end` out 1 — one-cycle pulse after the CRC beat of a forwarded line.
- `in_frame` out 1 — level: set by FS, cleared by FE.
- `ecc_err` out 1 — one-cycle pulse when a header fails its ECC check.
- `crc_err` out 1 — one-cycle pulse when the payload CRC mismatches.
- `pkt_err` out 1 — one-cycle pulse on a truncated packet, an odd WC, or WC > `MAX_WC`.

## Operation
- Header beats:
  - Beat0 = {WC[7:0], DI}.
  - Beat1 = {ECC, WC[15:8]}.
  - DT = DI[5:0]; VC = DI[7:6] is ignored.
- ECC: 6-bit CSI-2 Hamming code over the 24 bits {WC, DI}, with D0 = DI[0]. ECC[7:6] must be 0. The block only detects errors; there is no correction.
- FSM states are IDLE, HDR1, PAYLOAD, CRC and DRAIN:
  - IDLE: on the first valid beat, latch beat0 and go to HDR1.
  - HDR1: on a valid beat, run the ECC check.
    - Mismatch: pulse `ecc_err`, go to DRAIN.
    - Short packet (DT < 0x10): pulse FS or FE as appropriate; other short DTs are ignored. Go to DRAIN.
    - Long packet with odd WC or WC > `MAX_WC`: pulse `pkt_err`, go to DRAIN.
    - Long packet with WC = 0: go to CRC.
    - Otherwise: load the beat counter with WC/2, seed the CRC with 0xFFFF, go to PAYLOAD.
  - PAYLOAD: each valid beat decrements the counter and updates the CRC (lane0 byte first, LSB-first, polynomial x^16+x^12+x^5+1). If DT == `RAW_DT`, the beat is forwarded. When the counter reaches 0, go to CRC.
  - CRC: the beat is {CRC[15:8], CRC[7:0]}. Compare it with the running CRC; pulse `crc_err` on mismatch. Pulse `line_end` if the packet was forwarded, regardless of the CRC result. Go to DRAIN.
  - DRAIN: discard trailer beats until `data_in_valid` is low, then go to IDLE.
- `data_in_valid` low in HDR1, PAYLOAD or CRC: pulse `pkt_err` and go to IDLE. No `line_end` is issued, and `data_valid` drops immediately.
- `data_in_valid` low in IDLE or DRAIN: go to IDLE, with no error.
- `data_in_valid` high continuously from the start of a packet is required. There is no mid-packet stall.

## Timing
- All outputs are registered. Reset value of every output and of the FSM is 0 / IDLE.
- `data_out` and `data_valid` follow the matching `data_in` beat by exactly 1 cycle.
- `frame_start`, `frame_end`, `ecc_err` and `pkt_err` (size case) assert 1 cycle after header beat1.
- `crc_err` and `line_end` assert 1 cycle after the CRC beat.
- `in_frame` changes in the same cycle as `frame_start` or `frame_end`.
- Back-to-back packets need at least one cycle with `data_in_valid` low between them.
- Asynchronous reset mid-packet clears everything at once. The next packet is parsed from its first beat.

## Structure
- `top_pkg` additions:
  - DT constants `DT_FS`, `DT_FE`, `DT_LS`, `DT_LE`, `DT_RAW8`.
  - Function `csi_ecc(logic [23:0]) -> logic [5:0]`.
  - Function `crc16_byte(crc, byte)`.
  - FSM state enum `csi_dec_state_t`.
- One sub-module, `csi_crc16`, holds the 2-byte-per-cycle CRC register with seed, enable and result outputs. Two chained `crc16_byte` calls are combinational inside it.

## Test plan
- FS header beats 0x0000, 0x0000 (ECC 0x00), then FE (DI=0x01, ECC per `csi_ecc`):
  - `frame_start` pulses 1 cycle after the second beat.
  - `in_frame` is 1 until FE; `frame_end` pulses and `in_frame` returns to 0.
- RAW8 line, `MAX_WC`=1280:
  - Stimulus: beat0 0x002A, beat1 0x1505 (WC=0x0500, ECC 0x15), 640 payload beats, correct CRC beat.
  - Expected: 640 consecutive `data_valid` cycles with `data_out` equal to the input delayed 1 cycle, then one `line_end`, no errors.
- CRC vector, `MAX_WC` ≥ 24, WC=24:
  - Payload bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01.
  - CRC beat 0x00F0 → no `crc_err`.
  - CRC beat 0x00F1 → `crc_err` and `line_end` both pulse.
- Header ECC corruption: the RAW8 header with ECC 0x14 → `ecc_err` pulse, zero `data_valid` cycles.
- Non-RAW long packet (DT 0x12, WC=4) → no `data_valid`, no `line_end`, no errors.
- Truncation and reset:
  - `data_in_valid` dropped after 100 payload beats → `data_valid` falls the next cycle and `pkt_err` pulses. The following good line decodes normally.
  - `rst` asserted mid-payload → all outputs 0 immediately.

Source files
------------

// File: rtl/csi_pkt_decoder_pkg.sv
// Shared types, data-type codes and ECC/CRC helpers for the two-lane CSI-2 packet decoder.
package csi_pkt_decoder_pkg;

  typedef logic [15:0] lane_data_t;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LS   = 6'h02;
  localparam logic [5:0] DT_LE   = 6'h03;
  localparam logic [5:0] DT_RAW8 = 6'h2A;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  localparam logic [15:0] CRC_SEED     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REV = 16'h8408;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DRAIN   = 3'd4
  } csi_dec_state_t;

  // Each parity bit is the XOR of the header bits selected by its mask (bit n of the mask = D[n]).
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  // Reflected CRC-16 (x^16+x^12+x^5+1), data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[15:1]} ^ CRC_POLY_REV;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_pkt_decoder_if.sv
// Lane input stream and decoded outputs of the CSI-2 packet decoder.
interface csi_pkt_decoder_if;
  import csi_pkt_decoder_pkg::*;

  lane_data_t data_in;
  logic       data_in_valid;
  lane_data_t data_out;
  logic       data_valid;
  logic       frame_start;
  logic       frame_end;
  logic       line_end;
  logic       in_frame;
  logic       ecc_err;
  logic       crc_err;
  logic       pkt_err;

  modport master (
    output data_in, data_in_valid,
    input  data_out, data_valid, frame_start, frame_end, line_end, in_frame,
           ecc_err, crc_err, pkt_err
  );

  modport slave (
    input  data_in, data_in_valid,
    output data_out, data_valid, frame_start, frame_end, line_end, in_frame,
           ecc_err, crc_err, pkt_err
  );
endinterface

// File: rtl/csi_crc16.sv
// Payload CRC-16 register absorbing one lane pair (lane0 byte first) per enabled cycle.
module csi_crc16
  import csi_pkt_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_i,
  input  logic        en_i,
  input  lane_data_t  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_d;
  logic [15:0] crc_q;

  // Seed has priority so a new header always restarts the checksum.
  always_comb begin
    crc_d = crc_q;
    if (seed_i) begin
      crc_d = CRC_SEED;
    end else if (en_i) begin
      crc_d = crc16_byte(crc16_byte(crc_q, data_i[7:0]), data_i[15:8]);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/csi_pkt_decoder.sv
// Two-lane CSI-2 packet decoder: header ECC check, RAW payload forwarding, CRC check, frame/line strobes.
module csi_pkt_decoder
  import csi_pkt_decoder_pkg::*;
#(
  parameter logic [7:0]  RAW_DT = 8'h2A,
  parameter int unsigned MAX_WC = 1280
) (
  input logic              clk,
  input logic              rst,
  csi_pkt_decoder_if.slave bus
);

  localparam logic [15:0] MAX_WC_L = 16'(MAX_WC);

  csi_dec_state_t state_d, state_q;
  lane_data_t     hdr0_d, hdr0_q;
  logic [14:0]    cnt_d, cnt_q;
  logic           fwd_d, fwd_q;
  lane_data_t     data_out_d, data_out_q;
  logic           data_valid_d, data_valid_q;
  logic           frame_start_d, frame_start_q;
  logic           frame_end_d, frame_end_q;
  logic           line_end_d, line_end_q;
  logic           in_frame_d, in_frame_q;
  logic           ecc_err_d, ecc_err_q;
  logic           crc_err_d, crc_err_q;
  logic           pkt_err_d, pkt_err_q;

  logic           crc_seed_s;
  logic           crc_en_s;
  logic [15:0]    crc_s;
  logic [15:0]    wc_s;
  logic [7:0]     di_s;
  logic [5:0]     dt_s;
  logic           ecc_ok_s;

  // Header fields are valid while beat1 is on the bus in HDR1.
  assign di_s     = hdr0_q[7:0];
  assign dt_s     = di_s[5:0];
  assign wc_s     = {bus.data_in[7:0], hdr0_q[15:8]};
  assign ecc_ok_s = (bus.data_in[15:14] == 2'b00) && (bus.data_in[13:8] == csi_ecc({wc_s, di_s}));

  csi_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .seed_i (crc_seed_s),
    .en_i   (crc_en_s),
    .data_i (bus.data_in),
    .crc_o  (crc_s)
  );

  // Next-state and next-output logic; every strobe defaults low so it lasts exactly one cycle.
  always_comb begin
    state_d       = state_q;
    hdr0_d        = hdr0_q;
    cnt_d         = cnt_q;
    fwd_d         = fwd_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    line_end_d    = 1'b0;
    in_frame_d    = in_frame_q;
    ecc_err_d     = 1'b0;
    crc_err_d     = 1'b0;
    pkt_err_d     = 1'b0;
    crc_seed_s    = 1'b0;
    crc_en_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.data_in_valid) begin
          hdr0_d  = bus.data_in;
          state_d = ST_HDR1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HDR1: begin
        if (!bus.data_in_valid) begin
          pkt_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (!ecc_ok_s) begin
          ecc_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (dt_s < DT_LONG_MIN) begin
          if (dt_s == DT_FS) begin
            frame_start_d = 1'b1;
            in_frame_d    = 1'b1;
          end else if (dt_s == DT_FE) begin
            frame_end_d = 1'b1;
            in_frame_d  = 1'b0;
          end else begin
            in_frame_d = in_frame_q;
          end
          state_d = ST_DRAIN;
        end else if (wc_s[0] || (wc_s > MAX_WC_L)) begin
          pkt_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          fwd_d      = (dt_s == RAW_DT[5:0]);
          crc_seed_s = 1'b1;
          cnt_d      = wc_s[15:1];
          if (wc_s == 16'h0000) begin
            state_d = ST_CRC;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!bus.data_in_valid) begin
          pkt_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          crc_en_s     = 1'b1;
          cnt_d        = cnt_q - 15'd1;
          data_out_d   = bus.data_in;
          data_valid_d = fwd_q;
          if (cnt_q == 15'd1) begin
            state_d = ST_CRC;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_CRC: begin
        if (!bus.data_in_valid) begin
          pkt_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          crc_err_d  = (bus.data_in != crc_s);
          line_end_d = fwd_q;
          state_d    = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!bus.data_in_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hdr0_q        <= 16'h0000;
      cnt_q         <= 15'd0;
      fwd_q         <= 1'b0;
      data_out_q    <= 16'h0000;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      line_end_q    <= 1'b0;
      in_frame_q    <= 1'b0;
      ecc_err_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr0_q        <= hdr0_d;
      cnt_q         <= cnt_d;
      fwd_q         <= fwd_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      line_end_q    <= line_end_d;
      in_frame_q    <= in_frame_d;
      ecc_err_q     <= ecc_err_d;
      crc_err_q     <= crc_err_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.line_end    = line_end_q;
  assign bus.in_frame    = in_frame_q;
  assign bus.ecc_err     = ecc_err_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_csi_pkt_decoder.sv
// Scoreboard bench for csi_pkt_decoder: expected beats/strobes are queued with their due cycle.
module tb_csi_pkt_decoder;

  localparam logic [5:0] F_FS  = 6'b000001;
  localparam logic [5:0] F_FE  = 6'b000010;
  localparam logic [5:0] F_LE  = 6'b000100;
  localparam logic [5:0] F_ECC = 6'b001000;
  localparam logic [5:0] F_CRC = 6'b010000;
  localparam logic [5:0] F_PKT = 6'b100000;

  typedef struct { int cyc; logic [15:0] d; } dat_t;
  typedef struct { int cyc; logic [5:0] f; } evt_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  dat_t       dq[$];
  evt_t       eq[$];
  logic [7:0] byte_q[$];
  logic [7:0] vec24[24];
  logic       exp_in_frame = 1'b0;

  dat_t       dat_tmp;
  evt_t       evt_tmp;
  logic       exp_v;
  logic [15:0] exp_d;
  logic [5:0] exp_f;
  logic [5:0] obs_f;

  csi_pkt_decoder_if bus ();

  csi_pkt_decoder #(.RAW_DT(8'h2A), .MAX_WC(1280)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign obs_f = {bus.pkt_err, bus.crc_err, bus.ecc_err, bus.line_end, bus.frame_end, bus.frame_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      c = (c[0] ^ b[k]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_dat(input int c, input logic [15:0] d);
    dat_t t;
    t.cyc = c;
    t.d   = d;
    dq.push_back(t);
  endtask

  task automatic push_evt(input int c, input logic [5:0] f);
    evt_t t;
    t.cyc = c;
    t.f   = f;
    eq.push_back(t);
  endtask

  task automatic beat(input logic v, input logic [15:0] d);
    @(negedge clk);
    bus.data_in       = d;
    bus.data_in_valid = v;
  endtask

  task automatic fill_rand(input int n);
    byte_q.delete();
    for (int k = 0; k < n; k++) byte_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic fill_vec();
    byte_q.delete();
    for (int k = 0; k < 24; k++) byte_q.push_back(vec24[k]);
  endtask

  task automatic send_short(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                            input logic [5:0] flags);
    beat(1'b1, {wc[7:0], di});
    beat(1'b1, {ecc, wc[15:8]});
    if (flags != 6'h00) push_evt(cyc + 1, flags);
    beat(1'b0, 16'h0000);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.data_in_valid = 1'b0;
    #1;
    chk("rst_outputs", 32'({bus.data_valid, bus.data_out, obs_f, bus.in_frame}), 32'h0);
    dq.delete();
    eq.delete();
    exp_in_frame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // cut_at >= 0 stops the payload before that beat, either by dropping valid or by reset.
  task automatic send_line(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                           input logic [5:0] hdr_flags, input int cut_at, input logic cut_rst,
                           input logic crc_fixed, input logic [15:0] crc_val, input logic exp_crc_err);
    logic [15:0] crc;
    logic [15:0] d;
    logic [5:0]  flags;
    logic        fwd;
    int          n;
    beat(1'b1, {wc[7:0], di});
    beat(1'b1, {ecc, wc[15:8]});
    if (hdr_flags != 6'h00) begin
      push_evt(cyc + 1, hdr_flags);
      repeat (3) beat(1'b1, 16'hA5C3);
      beat(1'b0, 16'h0000);
      return;
    end
    fwd = (di[5:0] == 6'h2A);
    crc = 16'hFFFF;
    n   = int'(wc) / 2;
    for (int i = 0; i < n; i++) begin
      if (i == cut_at) begin
        if (cut_rst) begin
          reset_mid();
        end else begin
          beat(1'b0, 16'h0000);
          push_evt(cyc + 1, F_PKT);
        end
        return;
      end
      d = {byte_q[2*i+1], byte_q[2*i]};
      beat(1'b1, d);
      crc = crc_upd(crc_upd(crc, d[7:0]), d[15:8]);
      if (fwd) push_dat(cyc + 1, d);
    end
    if (crc_fixed) crc = crc_val;
    flags = (exp_crc_err ? F_CRC : 6'h00) | (fwd ? F_LE : 6'h00);
    beat(1'b1, crc);
    if (flags != 6'h00) push_evt(cyc + 1, flags);
    beat(1'b0, 16'h0000);
  endtask

  // Every cycle: pop whatever is due now and compare it with the DUT outputs.
  always @(negedge clk) begin
    exp_v = 1'b0;
    exp_d = 16'h0000;
    exp_f = 6'h00;
    if (dq.size() > 0 && dq[0].cyc <= cyc) begin
      dat_tmp = dq.pop_front();
      exp_v   = 1'b1;
      exp_d   = dat_tmp.d;
    end
    if (eq.size() > 0 && eq[0].cyc <= cyc) begin
      evt_tmp = eq.pop_front();
      exp_f   = evt_tmp.f;
    end
    if (exp_f[0]) exp_in_frame = 1'b1;
    if (exp_f[1]) exp_in_frame = 1'b0;
    chk("data_valid", 32'(bus.data_valid), 32'(exp_v));
    if (exp_v) chk("data_out", 32'(bus.data_out), 32'(exp_d));
    chk("strobes", 32'(obs_f), 32'(exp_f));
    chk("in_frame", 32'(bus.in_frame), 32'(exp_in_frame));
  end

  initial begin
    vec24 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
              8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    rst = 1'b1;
    bus.data_in = 16'h0000;
    bus.data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'({bus.data_valid, bus.data_out, obs_f, bus.in_frame}), 32'h0);

    send_short(8'h00, 16'h0000, 8'h00, F_FS);
    fill_rand(1280);
    send_line(8'h2A, 16'h0500, 8'h15, 6'h00, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
    fill_vec();
    send_line(8'h2A, 16'h0018, 8'h13, 6'h00, -1, 1'b0, 1'b1, 16'h00F0, 1'b0);
    send_line(8'h2A, 16'h0018, 8'h13, 6'h00, -1, 1'b0, 1'b1, 16'h00F1, 1'b1);
    send_line(8'h2A, 16'h0500, 8'h14, F_ECC, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
    fill_rand(4);
    send_line(8'h12, 16'h0004, 8'h3B, 6'h00, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_line(8'h2A, 16'h0000, 8'h10, 6'h00, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_line(8'h2A, 16'h0502, 8'h09, F_PKT, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_line(8'h2A, 16'h0003, 8'h16, F_PKT, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
    fill_rand(1280);
    send_line(8'h2A, 16'h0500, 8'h15, 6'h00, 100, 1'b0, 1'b0, 16'h0000, 1'b0);
    fill_vec();
    send_line(8'h2A, 16'h0018, 8'h13, 6'h00, -1, 1'b0, 1'b1, 16'h00F0, 1'b0);
    send_short(8'h01, 16'h0000, 8'h07, F_FE);

    send_short(8'h00, 16'h0000, 8'h00, F_FS);
    fill_rand(1280);
    send_line(8'h2A, 16'h0500, 8'h15, 6'h00, 50, 1'b1, 1'b0, 16'h0000, 1'b0);
    fill_vec();
    send_line(8'h2A, 16'h0018, 8'h13, 6'h00, -1, 1'b0, 1'b1, 16'h00F0, 1'b0);

    repeat (5) beat(1'b0, 16'h0000);
    chk("data_queue_left", 32'(dq.size()), 32'h0);
    chk("event_queue_left", 32'(eq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
